// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Shift-add multiply, restoring divide, one bit per cycle.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mf_req,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX
   } state_t;

   state_t             r_state;
   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dz;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;

   logic               w_is_div;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_madd;
   logic [WIDTH:0]     w_rsh;
   logic [WIDTH:0]     w_diff;
   logic               w_qbit;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_q;
   logic [WIDTH-1:0]   w_r;
   logic [2*WIDTH-1:0] w_prod_neg;

   assign w_is_div = r_op[1];
   assign w_a_neg  = ~r_op[0] & r_a[WIDTH-1];
   assign w_b_neg  = ~r_op[0] & r_b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? (~r_a + 1'b1) : r_a;
   assign w_b_mag  = w_b_neg ? (~r_b + 1'b1) : r_b;

   // Multiply: add multiplicand into upper half, then shift the whole product right.
   assign w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + (r_b[0] ? {1'b0, r_a} : '0);

   // Divide: upper half is the partial remainder, lower half collects quotient bits.
   assign w_rsh  = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
   assign w_diff = w_rsh - {1'b0, r_b};
   assign w_qbit = ~w_diff[WIDTH];
   assign w_rem  = w_qbit ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0];

   assign w_q        = r_acc[WIDTH-1:0];
   assign w_r        = r_acc[2*WIDTH-1:WIDTH];
   assign w_prod_neg = ~r_acc + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (hi_we) r_hi <= wdata;
               if (lo_we) r_lo <= wdata;
               if (start) begin
                  r_op    <= op;
                  r_a     <= src_a;
                  r_b     <= src_b;
                  r_busy  <= 1'b1;
                  r_state <= S_PREP;
               end
            end
            S_PREP: begin
               r_acc   <= '0;
               r_cnt   <= '0;
               r_neg_q <= w_a_neg ^ w_b_neg;
               r_neg_r <= w_a_neg;
               // Divide by zero keeps the raw dividend for HI.
               if (w_is_div && (r_b == '0)) begin
                  r_dz    <= 1'b1;
                  r_state <= S_FIX;
               end else begin
                  r_dz    <= 1'b0;
                  r_a     <= w_a_mag;
                  r_b     <= w_b_mag;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_is_div) begin
                  r_acc <= {w_rem, r_acc[WIDTH-2:0], w_qbit};
                  r_a   <= r_a << 1;
               end else begin
                  r_acc <= {w_madd, r_acc[WIDTH-1:1]};
                  r_b   <= r_b >> 1;
               end
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
            end
            S_FIX: begin
               if (!w_is_div) begin
                  {r_hi, r_lo} <= r_neg_q ? w_prod_neg : r_acc;
               end else if (r_dz) begin
                  r_hi <= r_a;
                  r_lo <= '1;
               end else begin
                  r_lo <= r_neg_q ? (~w_q + 1'b1) : w_q;
                  r_hi <= r_neg_r ? (~w_r + 1'b1) : w_r;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign hi    = r_hi;
   assign lo    = r_lo;
   assign busy  = r_busy;
   assign done  = r_done;
   assign stall = r_busy & (start | mf_req | hi_we | lo_we);

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq.
// Expected HI/LO come from native SV arithmetic.
module tb_muldiv_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] src_a;
   logic [W-1:0] src_b;
   logic         mf_req;
   logic         hi_we;
   logic         lo_we;
   logic [W-1:0] wdata;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         stall;

   int n_vec = 0;
   int n_bad = 0;
   logic [2*W-1:0] sb_q[$];

   muldiv_seq #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .mf_req (mf_req),
      .hi_we  (hi_we),
      .lo_we  (lo_we),
      .wdata  (wdata),
      .hi     (hi),
      .lo     (lo),
      .busy   (busy),
      .done   (done),
      .stall  (stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      res = '0;
      case (o)
         2'd0: res = sa * sb;
         2'd1: res = ua * ub;
         2'd2: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else begin
               uq = ua / ub;
               ur = ua % ub;
               res = {ur[31:0], uq[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   task automatic issue(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      sb_q.push_back(model(o, a, b));
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_lat,
                            input bit probe);
      int cyc;
      bit seen;
      logic [63:0] prev;
      logic [63:0] exp;
      cyc  = 0;
      seen = 1'b0;
      prev = {hi, lo};
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (probe && i == 5) begin
            check({tag, "_busy"}, busy, 1);
            mf_req = 1'b1;
            #1 check({tag, "_mfstall"}, stall, 1);
            check({tag, "_nopartial"}, {hi, lo}, prev);
            mf_req = 1'b0;
         end
         if (done) begin
            cyc  = i;
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         check({tag, "_timeout"}, 0, 1);
         return;
      end
      check({tag, "_lat"}, cyc, exp_lat);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
      check({tag, "_hilo"}, {hi, lo}, exp);
      @(posedge clk);
      #1 check({tag, "_done1"}, done, 0);
   endtask

   task automatic do_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit probe);
      issue(o, a, b);
      wait_done(tag, (o[1] && b == 32'h0) ? 2 : 34, probe);
   endtask

   initial begin
      int nostall;
      bit seen;
      logic [63:0] exp;
      logic [1:0] ro;
      logic [31:0] ra, rb;

      rst = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
      mf_req = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

      repeat (2) @(negedge clk);
      mf_req = 1'b1;
      #1;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall, 0);
      mf_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      do_op("multu3x3", 2'd1, 32'd3, 32'd3, 1'b1);
      do_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
      do_op("div15_2", 2'd2, 32'd15, 32'd2, 1'b0);
      do_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      do_op("divu14_4", 2'd3, 32'd14, 32'd4, 1'b0);
      do_op("div_by0", 2'd2, 32'd14, 32'd0, 1'b0);
      do_op("divu_by0", 2'd3, 32'hDEAD_BEEF, 32'd0, 1'b0);
      do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      do_op("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      do_op("div_neg_neg", 2'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);

      for (int k = 0; k < 6; k++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (k == 3) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
         do_op("rand", ro, ra, rb, 1'b0);
      end

      // Second start held while busy.
      @(negedge clk);
      start = 1'b1; op = 2'd1; src_a = 32'd6; src_b = 32'd7;
      sb_q.push_back(model(2'd1, 32'd6, 32'd7));
      @(posedge clk);
      #1;
      op = 2'd2; src_a = 32'd100; src_b = 32'd7;
      sb_q.push_back(model(2'd2, 32'd100, 32'd7));
      nostall = 0;
      seen = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (!stall) nostall++;
      end
      check("b2b_seen", seen, 1);
      check("b2b_stall", nostall, 0);
      check("b2b_accept", stall, 0);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
      check("b2b1_hilo", {hi, lo}, exp);
      @(posedge clk);
      #1 start = 1'b0;
      check("b2b2_busy", busy, 1);
      wait_done("b2b2", 34, 1'b0);

      // Abort mid-run with reset at counter 10.
      @(negedge clk);
      start = 1'b1; op = 2'd3; src_a = 32'd1000; src_b = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (11) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      @(negedge clk);
      rst = 1'b1;
      do_op("after_rst", 2'd1, 32'd12345, 32'd678, 1'b0);

      @(negedge clk);
      lo_we = 1'b1; wdata = 32'h1234;
      #1 check("mtlo_stall", stall, 0);
      @(posedge clk);
      #1 check("mtlo_lo", lo, 32'h1234);
      lo_we = 1'b0;

      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_5A5A;
      @(posedge clk);
      #1 check("mt_both", {hi, lo}, {32'hA5A5_5A5A, 32'hA5A5_5A5A});
      hi_we = 1'b0; lo_we = 1'b0;

      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h77;
      start = 1'b1; op = 2'd1; src_a = 32'd2; src_b = 32'd5;
      sb_q.push_back(model(2'd1, 32'd2, 32'd5));
      @(posedge clk);
      #1 start = 1'b0;
      hi_we = 1'b0;
      check("mthi_first", hi, 32'h77);
      wait_done("mthi_start", 34, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
